// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM stage of the 5-stage RV32 pipeline.
// Takes the EX/MEM register outputs, issues word loads/stores to a multi-cycle
// data memory over a req/ack handshake, holds the upstream pipeline while an
// access is outstanding, and registers the MEM/WB bundle.
//
// Optional feature: define MEM_TIMEOUT_EN to abort an access that waits
// MEM_TIMEOUT cycles without mem_ack_i (sticky err_o). Without it WAIT lasts
// until the ack arrives and err_o is tied to 0.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   RegWrite_i .. RDaddr_i   EX/MEM register outputs
//   stall_o                  combinational hold for PC/IF/ID/ID-EX/EX-MEM
//   mem_req_o/we/addr/wdata  registered memory request
//   mem_ack_i, mem_rdata_i   one-cycle completion pulse and read data
//   RegWrite_o .. RDaddr_o   MEM/WB register
//   misalign_o               one-cycle pulse when a misaligned access is dropped
//   err_o                    sticky timeout flag
module mem_access_stage #(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        RegWrite_i,
   input  logic        MemtoReg_i,
   input  logic        MemRead_i,
   input  logic        MemWrite_i,
   input  logic [31:0] ALUresult_i,
   input  logic [31:0] RS2data_i,
   input  logic [4:0]  RDaddr_i,
   output logic        stall_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        RegWrite_o,
   output logic        MemtoReg_o,
   output logic [31:0] ALUresult_o,
   output logic [31:0] MemData_o,
   output logic [4:0]  RDaddr_o,
   output logic        misalign_o,
   output logic        err_o
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t state;
   logic   acc;
   logic   mis;
   logic   tmo;

   // Reject illegal timeout values at elaboration.
   if (MEM_TIMEOUT < 2 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("mem_access_stage: MEM_TIMEOUT must be in 2..255");
   end

   assign acc = MemRead_i | MemWrite_i;
   assign mis = acc & (ALUresult_i[1:0] != 2'b00);

`ifdef MEM_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
   logic [7:0] wait_cnt;
   logic       err_q;

   // Fires in the MEM_TIMEOUT-th WAIT cycle without ack; an ack in that cycle wins.
   assign tmo   = (state == S_WAIT) && !mem_ack_i && (wait_cnt == TMO_LAST);
   assign err_o = err_q;
`else
   assign tmo   = 1'b0;
   assign err_o = 1'b0;
`endif

   // Upstream hold: issuing cycle in IDLE, then every WAIT cycle that does not finish.
   always_comb begin
      stall_o = 1'b0;
      case (state)
         S_IDLE:  stall_o = acc & ~mis;
         S_WAIT:  stall_o = ~mem_ack_i & ~tmo;
         default: stall_o = 1'b0;
      endcase
   end

   // Stage FSM with registered memory request and MEM/WB bundle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         RegWrite_o  <= 1'b0;
         MemtoReg_o  <= 1'b0;
         ALUresult_o <= '0;
         MemData_o   <= '0;
         RDaddr_o    <= '0;
         misalign_o  <= 1'b0;
`ifdef MEM_TIMEOUT_EN
         wait_cnt    <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         misalign_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!acc) begin
                  RegWrite_o  <= RegWrite_i;
                  MemtoReg_o  <= MemtoReg_i;
                  ALUresult_o <= ALUresult_i;
                  RDaddr_o    <= RDaddr_i;
                  MemData_o   <= '0;
               end else begin
                  // Both the dropped misaligned access and the issue cycle write a bubble.
                  RegWrite_o  <= 1'b0;
                  MemtoReg_o  <= 1'b0;
                  ALUresult_o <= '0;
                  RDaddr_o    <= '0;
                  MemData_o   <= '0;
                  if (mis) begin
                     misalign_o <= 1'b1;
                  end else begin
                     // Read+write together is treated as a write.
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= MemWrite_i;
                     mem_addr_o  <= ALUresult_i;
                     mem_wdata_o <= RS2data_i;
                     state       <= S_WAIT;
`ifdef MEM_TIMEOUT_EN
                     wait_cnt    <= '0;
`endif
                  end
               end
            end
            S_WAIT: begin
               if (mem_ack_i) begin
                  mem_req_o   <= 1'b0;
                  RegWrite_o  <= RegWrite_i;
                  MemtoReg_o  <= MemtoReg_i;
                  ALUresult_o <= ALUresult_i;
                  RDaddr_o    <= RDaddr_i;
                  MemData_o   <= mem_we_o ? 32'h0 : mem_rdata_i;
                  state       <= S_IDLE;
               end else if (tmo) begin
                  mem_req_o   <= 1'b0;
                  RegWrite_o  <= 1'b0;
                  MemtoReg_o  <= 1'b0;
                  ALUresult_o <= '0;
                  RDaddr_o    <= '0;
                  MemData_o   <= '0;
                  state       <= S_IDLE;
`ifdef MEM_TIMEOUT_EN
                  err_q       <= 1'b1;
`endif
               end else begin
`ifdef MEM_TIMEOUT_EN
                  wait_cnt    <= wait_cnt + 8'd1;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
